// File: rtl/hazard_pkg.sv
// Shared constants and register-match helpers for the hazard/scoreboard unit.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned RF_INT = 0;
    localparam int unsigned RF_FP  = 1;

    // True when (a, ra) names a hardwired-zero register.
    function automatic logic is_zero_reg(input logic [31:0] a, input logic [31:0] ra,
                                         input logic [31:0] zero_mask);
        logic [31:0] sel;
        sel = zero_mask >> ra;
        return sel[0] && (a == '0);
    endfunction

    function automatic logic reg_match(input logic [31:0] a, input logic [31:0] ra,
                                       input logic [31:0] b, input logic [31:0] rb,
                                       input logic [31:0] zero_mask);
        return (a == b) && (ra == rb) && !is_zero_reg(a, ra, zero_mask);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// One-operand E-stage forward selector; M result has priority over W.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned AW        = 5,
    parameter int unsigned RFW       = 1,
    parameter logic [31:0] ZERO_MASK = 32'h1
) (
    input  logic [AW-1:0]  rs,
    input  logic [RFW-1:0] rs_rf,
    input  logic [AW-1:0]  rd_m,
    input  logic [RFW-1:0] rd_rf_m,
    input  logic           reg_write_m,
    input  logic [AW-1:0]  rd_w,
    input  logic [RFW-1:0] rd_rf_w,
    input  logic           reg_write_w,
    output logic [1:0]     fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m &&
            reg_match(32'(rd_m), 32'(rd_rf_m), 32'(rs), 32'(rs_rf), ZERO_MASK)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w &&
                     reg_match(32'(rd_w), 32'(rd_rf_w), 32'(rs), 32'(rs_rf), ZERO_MASK)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Multi-RF forwarding, load-use/branch hazard control and a long-latency scoreboard
// with outstanding-op accounting, sticky error flag and stall-cycle counter.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned        NUM_RF       = 2,
    parameter int unsigned        AW           = 5,
    parameter int unsigned        RFW          = 1,
    parameter logic [NUM_RF-1:0]  ZERO_RF_MASK = 2'b01,
    parameter int unsigned        MC_DEPTH     = 4,
    parameter int unsigned        CNT_W        = 32,
    localparam int unsigned       NUM_REGS     = 2 ** AW,
    localparam int unsigned       SB_W         = NUM_RF * NUM_REGS,
    localparam int unsigned       MC_W         = $clog2(MC_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid_d,
    input  logic [AW-1:0]    rs1_d,
    input  logic [AW-1:0]    rs2_d,
    input  logic [AW-1:0]    rs3_d,
    input  logic [RFW-1:0]   rs1_rf_d,
    input  logic [RFW-1:0]   rs2_rf_d,
    input  logic [RFW-1:0]   rs3_rf_d,
    input  logic [2:0]       rs_used_d,
    input  logic [AW-1:0]    rd_d,
    input  logic [RFW-1:0]   rd_rf_d,
    input  logic             rd_we_d,
    input  logic             long_lat_d,
    input  logic [AW-1:0]    rs1_e,
    input  logic [AW-1:0]    rs2_e,
    input  logic [AW-1:0]    rs3_e,
    input  logic [RFW-1:0]   rs1_rf_e,
    input  logic [RFW-1:0]   rs2_rf_e,
    input  logic [RFW-1:0]   rs3_rf_e,
    input  logic [AW-1:0]    rd_e,
    input  logic [RFW-1:0]   rd_rf_e,
    input  logic             reg_write_e,
    input  logic             mem_read_e,
    input  logic [AW-1:0]    rd_m,
    input  logic [RFW-1:0]   rd_rf_m,
    input  logic             reg_write_m,
    input  logic [AW-1:0]    rd_w,
    input  logic [RFW-1:0]   rd_rf_w,
    input  logic             reg_write_w,
    input  logic             lc_valid,
    input  logic [AW-1:0]    lc_rd,
    input  logic [RFW-1:0]   lc_rf,
    input  logic             flush_in,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic [1:0]       forward_c_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [SB_W-1:0]  sb_busy,
    output logic [MC_W-1:0]  mc_count,
    output logic             sb_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [31:0] ZMASK = 32'(ZERO_RF_MASK);

    function automatic logic [31:0] sb_idx(input logic [RFW-1:0] rf, input logic [AW-1:0] r);
        return 32'(rf) * NUM_REGS + 32'(r);
    endfunction

    // Shift-based select: an out-of-range index reads as 0 instead of X.
    function automatic logic bit_at(input logic [SB_W-1:0] v, input logic [31:0] idx);
        logic [SB_W-1:0] s;
        s = v >> idx;
        return s[0];
    endfunction

    logic [SB_W-1:0]  busy_q, busy_d, lc_mask, set_mask, eff_busy;
    logic [MC_W-1:0]  mc_count_q, mc_count_d;
    logic             sb_error_q, sb_error_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [AW-1:0]  rs_d [3];
    logic [RFW-1:0] rs_rf_d [3];
    logic [AW-1:0]  rs_e [3];
    logic [RFW-1:0] rs_rf_e [3];
    logic [1:0]     fwd [3];

    logic [31:0] lc_idx;
    logic        load_use, raw_sb, waw_sb, struct_hz, hz, accept, do_set, mc_full;

    assign rs_d[0] = rs1_d;    assign rs_d[1] = rs2_d;    assign rs_d[2] = rs3_d;
    assign rs_rf_d[0] = rs1_rf_d; assign rs_rf_d[1] = rs2_rf_d; assign rs_rf_d[2] = rs3_rf_d;
    assign rs_e[0] = rs1_e;    assign rs_e[1] = rs2_e;    assign rs_e[2] = rs3_e;
    assign rs_rf_e[0] = rs1_rf_e; assign rs_rf_e[1] = rs2_rf_e; assign rs_rf_e[2] = rs3_rf_e;

    for (genvar k = 0; k < 3; k++) begin : g_fwd
        hazard_fwd_sel #(
            .AW        (AW),
            .RFW       (RFW),
            .ZERO_MASK (ZMASK)
        ) u_fwd_sel (
            .rs          (rs_e[k]),
            .rs_rf       (rs_rf_e[k]),
            .rd_m        (rd_m),
            .rd_rf_m     (rd_rf_m),
            .reg_write_m (reg_write_m),
            .rd_w        (rd_w),
            .rd_rf_w     (rd_rf_w),
            .reg_write_w (reg_write_w),
            .fwd         (fwd[k])
        );
    end

    assign forward_a_e = rst ? 2'b00 : fwd[0];
    assign forward_b_e = rst ? 2'b00 : fwd[1];
    assign forward_c_e = rst ? 2'b00 : fwd[2];

    // Write-before-read RF: a register completing this cycle is already readable.
    assign lc_idx   = sb_idx(lc_rf, lc_rd);
    assign lc_mask  = lc_valid ? (SB_W'(1) << lc_idx) : '0;
    assign eff_busy = busy_q & ~lc_mask;
    assign mc_full  = (mc_count_q == MC_W'(MC_DEPTH));

    always_comb begin
        load_use = 1'b0;
        raw_sb   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (rs_used_d[k]) begin
                load_use = load_use | (mem_read_e & reg_write_e &
                           reg_match(32'(rd_e), 32'(rd_rf_e), 32'(rs_d[k]), 32'(rs_rf_d[k]),
                                     ZMASK));
                raw_sb   = raw_sb | bit_at(eff_busy, sb_idx(rs_rf_d[k], rs_d[k]));
            end
        end
        waw_sb    = rd_we_d & bit_at(eff_busy, sb_idx(rd_rf_d, rd_d));
        struct_hz = long_lat_d & mc_full & ~lc_valid;
        hz        = ~rst & issue_valid_d & (load_use | raw_sb | waw_sb | struct_hz);
    end

    assign stall_f = hz & ~flush_in;
    assign stall_d = hz & ~flush_in;
    assign flush_d = ~rst & flush_in;
    assign flush_e = ~rst & (flush_in | hz);

    assign accept   = ~rst & issue_valid_d & ~hz & ~flush_in;
    assign do_set   = accept & long_lat_d & rd_we_d &
                      ~is_zero_reg(32'(rd_d), 32'(rd_rf_d), ZMASK);
    assign set_mask = do_set ? (SB_W'(1) << sb_idx(rd_rf_d, rd_d)) : '0;

    always_comb begin
        busy_d     = (busy_q & ~lc_mask) | set_mask;
        mc_count_d = mc_count_q;
        if ((accept & long_lat_d) && !lc_valid) begin
            mc_count_d = mc_count_q + MC_W'(1);
        end else if (lc_valid && !(accept & long_lat_d) && mc_count_q != '0) begin
            mc_count_d = mc_count_q - MC_W'(1);
        end
        sb_error_d = sb_error_q
                   | (lc_valid & ((mc_count_q == '0) | ~bit_at(busy_q, lc_idx)))
                   | (do_set & mc_full & ~lc_valid);
        stall_cycles_d = stall_cycles_q;
        if (stall_d && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q         <= '0;
            mc_count_q     <= '0;
            sb_error_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            busy_q         <= busy_d;
            mc_count_q     <= mc_count_d;
            sb_error_q     <= sb_error_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb_busy      = busy_q;
    assign mc_count     = mc_count_q;
    assign sb_error     = sb_error_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (default parameters).
module tb_hazard_scoreboard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_d;
    logic [4:0]  rs1_d, rs2_d, rs3_d, rd_d;
    logic        rs1_rf_d, rs2_rf_d, rs3_rf_d, rd_rf_d;
    logic [2:0]  rs_used_d;
    logic        rd_we_d, long_lat_d;
    logic [4:0]  rs1_e, rs2_e, rs3_e, rd_e, rd_m, rd_w, lc_rd;
    logic        rs1_rf_e, rs2_rf_e, rs3_rf_e, rd_rf_e, rd_rf_m, rd_rf_w, lc_rf;
    logic        reg_write_e, mem_read_e, reg_write_m, reg_write_w, lc_valid, flush_in;
    logic [1:0]  forward_a_e, forward_b_e, forward_c_e;
    logic        stall_f, stall_d, flush_d, flush_e, sb_error;
    logic [63:0] sb_busy;
    logic [2:0]  mc_count;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_stalls = 0;

    hazard_scoreboard_unit dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_d (issue_valid_d),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rs3_d         (rs3_d),
        .rs1_rf_d      (rs1_rf_d),
        .rs2_rf_d      (rs2_rf_d),
        .rs3_rf_d      (rs3_rf_d),
        .rs_used_d     (rs_used_d),
        .rd_d          (rd_d),
        .rd_rf_d       (rd_rf_d),
        .rd_we_d       (rd_we_d),
        .long_lat_d    (long_lat_d),
        .rs1_e         (rs1_e),
        .rs2_e         (rs2_e),
        .rs3_e         (rs3_e),
        .rs1_rf_e      (rs1_rf_e),
        .rs2_rf_e      (rs2_rf_e),
        .rs3_rf_e      (rs3_rf_e),
        .rd_e          (rd_e),
        .rd_rf_e       (rd_rf_e),
        .reg_write_e   (reg_write_e),
        .mem_read_e    (mem_read_e),
        .rd_m          (rd_m),
        .rd_rf_m       (rd_rf_m),
        .reg_write_m   (reg_write_m),
        .rd_w          (rd_w),
        .rd_rf_w       (rd_rf_w),
        .reg_write_w   (reg_write_w),
        .lc_valid      (lc_valid),
        .lc_rd         (lc_rd),
        .lc_rf         (lc_rf),
        .flush_in      (flush_in),
        .forward_a_e   (forward_a_e),
        .forward_b_e   (forward_b_e),
        .forward_c_e   (forward_c_e),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .sb_busy       (sb_busy),
        .mc_count      (mc_count),
        .sb_error      (sb_error),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        issue_valid_d = 0; rs1_d = 0; rs2_d = 0; rs3_d = 0; rd_d = 0;
        rs1_rf_d = 0; rs2_rf_d = 0; rs3_rf_d = 0; rd_rf_d = 0; rs_used_d = 0;
        rd_we_d = 0; long_lat_d = 0;
        rs1_e = 0; rs2_e = 0; rs3_e = 0; rs1_rf_e = 0; rs2_rf_e = 0; rs3_rf_e = 0;
        rd_e = 0; rd_rf_e = 0; reg_write_e = 0; mem_read_e = 0;
        rd_m = 0; rd_rf_m = 0; reg_write_m = 0; rd_w = 0; rd_rf_w = 0; reg_write_w = 0;
        lc_valid = 0; lc_rd = 0; lc_rf = 0; flush_in = 0;
    endtask

    // Drive at negedge, let comb logic settle.
    task automatic at_negedge();
        @(negedge clk);
        idle();
    endtask

    task automatic after_posedge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        reg_write_m = 1; rd_m = 5; rs1_e = 5; flush_in = 1;
        #3;
        checks++; if (forward_a_e !== 2'b00) begin errors++; $display("FAIL rst_fwd got %b want 00", forward_a_e); end
        checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL rst_flush_d got %b want 0", flush_d); end
        checks++; if (sb_busy !== 64'h0 || mc_count !== 3'd0) begin errors++; $display("FAIL rst_state busy %h cnt %0d want 0 0", sb_busy, mc_count); end
        checks++; if (sb_error !== 1'b0 || stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_err_cnt err %b cyc %0d want 0 0", sb_error, stall_cycles); end
        @(negedge clk);
        rst = 0;
        idle();
    endtask

    task automatic test_fwd_priority();
        at_negedge();
        reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5; rs1_e = 5;
        #1;
        checks++; if (forward_a_e !== 2'b10) begin errors++; $display("FAIL fwd_m_over_w got %b want 10", forward_a_e); end
        rd_rf_m = 1;
        #1;
        checks++; if (forward_a_e !== 2'b01) begin errors++; $display("FAIL fwd_rf_mismatch got %b want 01", forward_a_e); end
        reg_write_w = 0;
        #1;
        checks++; if (forward_a_e !== 2'b00) begin errors++; $display("FAIL fwd_none got %b want 00", forward_a_e); end
        rs3_e = 9; rs3_rf_e = 1; rd_w = 9; rd_rf_w = 1; reg_write_w = 1;
        #1;
        checks++; if (forward_c_e !== 2'b01) begin errors++; $display("FAIL fwd_c_wb got %b want 01", forward_c_e); end
    endtask

    task automatic test_zero_reg();
        at_negedge();
        reg_write_m = 1; rd_m = 0; rd_rf_m = 1; rs2_e = 0; rs2_rf_e = 1;
        #1;
        checks++; if (forward_b_e !== 2'b10) begin errors++; $display("FAIL fwd_fp_f0 got %b want 10", forward_b_e); end
        rd_rf_m = 0; rs2_rf_e = 0; reg_write_w = 1; rd_w = 0; rd_rf_w = 0;
        #1;
        checks++; if (forward_b_e !== 2'b00) begin errors++; $display("FAIL fwd_int_x0 got %b want 00", forward_b_e); end
    endtask

    task automatic test_load_use();
        at_negedge();
        issue_valid_d = 1; rs2_d = 7; rs_used_d = 3'b010;
        mem_read_e = 1; reg_write_e = 1; rd_e = 7;
        #1;
        checks++; if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin errors++; $display("FAIL load_use_stall got %b want 1110", {stall_f, stall_d, flush_e, flush_d}); end
        exp_stalls++;
        at_negedge();
        issue_valid_d = 1; rs2_d = 7; rs_used_d = 3'b010; reg_write_m = 1; rd_m = 7;
        #1;
        checks++; if ({stall_d, flush_e} !== 2'b00) begin errors++; $display("FAIL load_use_release got %b want 00", {stall_d, flush_e}); end
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL load_use_count got %0d want 1", stall_cycles); end
        at_negedge();
        issue_valid_d = 1; rs2_d = 7; rs_used_d = 3'b010;
        mem_read_e = 1; reg_write_e = 1; rd_e = 7; flush_in = 1;
        #1;
        checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin errors++; $display("FAIL load_use_flush got %b want 0011", {stall_f, stall_d, flush_d, flush_e}); end
        after_posedge();
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL flush_no_count got %0d want 1", stall_cycles); end
    endtask

    task automatic test_scoreboard();
        at_negedge();
        issue_valid_d = 1; long_lat_d = 1; rd_d = 3; rd_rf_d = 1; rd_we_d = 1;
        #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL fdiv_issue got %b want 0", stall_d); end
        after_posedge();
        checks++; if (sb_busy !== 64'h8_0000_0000 || mc_count !== 3'd1) begin errors++; $display("FAIL fdiv_busy busy %h cnt %0d want 800000000 1", sb_busy, mc_count); end
        at_negedge();
        issue_valid_d = 1; rs1_d = 3; rs1_rf_d = 1; rs_used_d = 3'b001;
        #1;
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL raw_sb got %b want 1", stall_d); end
        exp_stalls++;
        at_negedge();
        issue_valid_d = 1; rd_d = 3; rd_rf_d = 1; rd_we_d = 1;
        #1;
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL waw_sb got %b want 1", stall_d); end
        exp_stalls++;
        at_negedge();
        issue_valid_d = 1; rs1_d = 3; rs1_rf_d = 1; rs_used_d = 3'b001;
        lc_valid = 1; lc_rd = 3; lc_rf = 1;
        #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lc_bypass got %b want 0", stall_d); end
        after_posedge();
        checks++; if (sb_busy !== 64'h0 || mc_count !== 3'd0 || sb_error !== 1'b0) begin errors++; $display("FAIL fdiv_done busy %h cnt %0d err %b want 0 0 0", sb_busy, mc_count, sb_error); end
    endtask

    task automatic test_structural();
        for (int i = 1; i <= 4; i++) begin
            at_negedge();
            issue_valid_d = 1; long_lat_d = 1; rd_we_d = 1; rd_d = 5'(i);
            #1;
            checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL struct_issue%0d got %b want 0", i, stall_d); end
        end
        after_posedge();
        checks++; if (mc_count !== 3'd4 || sb_busy !== 64'h1E) begin errors++; $display("FAIL struct_full cnt %0d busy %h want 4 1e", mc_count, sb_busy); end
        at_negedge();
        issue_valid_d = 1; long_lat_d = 1; rd_we_d = 1; rd_d = 5;
        #1;
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL struct_stall got %b want 1", stall_d); end
        exp_stalls++;
        at_negedge();
        issue_valid_d = 1; long_lat_d = 1; rd_we_d = 1; rd_d = 5;
        lc_valid = 1; lc_rd = 1;
        #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL struct_release got %b want 0", stall_d); end
        after_posedge();
        checks++; if (mc_count !== 3'd4 || sb_busy !== 64'h3C || sb_error !== 1'b0) begin errors++; $display("FAIL struct_swap cnt %0d busy %h err %b want 4 3c 0", mc_count, sb_busy, sb_error); end
        for (int i = 2; i <= 5; i++) begin
            at_negedge();
            lc_valid = 1; lc_rd = 5'(i);
        end
        after_posedge();
        checks++; if (mc_count !== 3'd0 || sb_busy !== 64'h0 || sb_error !== 1'b0) begin errors++; $display("FAIL struct_drain cnt %0d busy %h err %b want 0 0 0", mc_count, sb_busy, sb_error); end
        checks++; if (stall_cycles !== 32'(exp_stalls)) begin errors++; $display("FAIL stall_count got %0d want %0d", stall_cycles, exp_stalls); end
    endtask

    task automatic test_errors();
        at_negedge();
        lc_valid = 1; lc_rd = 9;
        after_posedge();
        checks++; if (sb_error !== 1'b1 || mc_count !== 3'd0) begin errors++; $display("FAIL lc_underflow err %b cnt %0d want 1 0", sb_error, mc_count); end
        at_negedge();
        after_posedge();
        checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", sb_error); end
    endtask

    task automatic test_reset_mid();
        at_negedge();
        issue_valid_d = 1; long_lat_d = 1; rd_we_d = 1; rd_d = 6;
        at_negedge();
        issue_valid_d = 1; rs1_d = 6; rs_used_d = 3'b001;
        reg_write_m = 1; rd_m = 6; rs1_e = 6;
        #1;
        checks++; if (stall_d !== 1'b1 || sb_busy !== 64'h40) begin errors++; $display("FAIL pre_rst stall %b busy %h want 1 40", stall_d, sb_busy); end
        exp_stalls++;
        #1;
        rst = 1;
        #1;
        checks++; if ({stall_f, stall_d, flush_d, flush_e, forward_a_e} !== 6'b0) begin errors++; $display("FAIL rst_comb got %b want 000000", {stall_f, stall_d, flush_d, flush_e, forward_a_e}); end
        checks++; if (sb_busy !== 64'h0 || mc_count !== 3'd0 || sb_error !== 1'b0 || stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_async busy %h cnt %0d err %b cyc %0d want 0 0 0 0", sb_busy, mc_count, sb_error, stall_cycles); end
        flush_in = 1;
        #1;
        checks++; if (flush_d !== 1'b0 || flush_e !== 1'b0) begin errors++; $display("FAIL rst_flush got %b%b want 00", flush_d, flush_e); end
        at_negedge();
        lc_valid = 1; lc_rd = 6;
        at_negedge();
        rst = 0;
        #1;
        checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL lc_during_rst got %b want 0", sb_error); end
        lc_valid = 1; lc_rd = 6;
        after_posedge();
        checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL lc_after_rst got %b want 1", sb_error); end
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_zero_reg();
        test_load_use();
        test_scoreboard();
        test_structural();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
